// File: rtl/frame_tester_pkg.sv
// Shared definitions for the frame tester (checker and generator).
// FSM encoding, test-frame header layout and stats selector codes.
package frame_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;
    localparam logic [15:0] MIN_FRAME_LEN  = 16'd60;

    localparam int OFF_ETYPE = 12;
    localparam int OFF_SEQ   = 14;
    localparam int HDR_BYTES = 18;

    localparam logic [1:0] SEL_FRAMES = 2'd0;
    localparam logic [1:0] SEL_BYTES  = 2'd1;
    localparam logic [1:0] SEL_SEQERR = 2'd2;
    localparam logic [1:0] SEL_BAD    = 2'd3;

endpackage

// File: rtl/frame_checker_if.sv
// AXI-Stream bundle feeding the frame checker.
// The master drives the beat, the slave returns ready.
interface frame_checker_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3
);
    logic [DATA_WIDTH-1:0]   axis_s_data;
    logic [DATA_WIDTH/8-1:0] axis_s_keep;
    logic                    axis_s_last;
    logic [DATA_WIDTH/8-1:0] axis_s_user;
    logic [ID_WIDTH-1:0]     axis_s_id;
    logic                    axis_s_valid;
    logic                    axis_s_ready;

    modport master (
        output axis_s_data, axis_s_keep, axis_s_last,
        output axis_s_user, axis_s_id, axis_s_valid,
        input  axis_s_ready
    );

    modport slave (
        input  axis_s_data, axis_s_keep, axis_s_last,
        input  axis_s_user, axis_s_id, axis_s_valid,
        output axis_s_ready
    );
endinterface

// File: rtl/frame_checker_stats.sv
// Per-id counter bank, expected-sequence RAM and stats readout.
// Frames arrive one per cycle max; the seq check sits one stage ahead of commit.
module frame_checker_stats
    import frame_tester_pkg::*;
#(
    parameter int ID_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_vld,
    input  logic [ID_WIDTH-1:0] i_id,
    input  logic [31:0]         i_seq,
    input  logic [15:0]         i_len,
    input  logic                i_bad,
    input  logic [ID_WIDTH-1:0] i_port,
    input  logic [1:0]          i_sel,
    output logic [63:0]         o_data
);
    localparam int NPORT = 1 << ID_WIDTH;

    logic [47:0]         r_frames [NPORT];
    logic [63:0]         r_bytes  [NPORT];
    logic [31:0]         r_serr   [NPORT];
    logic [31:0]         r_bad    [NPORT];
    logic [31:0]         r_exp    [NPORT];
    logic [NPORT-1:0]    r_seq_vld;
    logic                r_s2_vld;
    logic [ID_WIDTH-1:0] r_s2_id;
    logic [15:0]         r_s2_len;
    logic                r_s2_bad;
    logic                r_s2_serr;
    logic [63:0]         r_data;
    logic                w_good;
    logic                w_serr;
    logic [63:0]         w_rd;

    assign w_good = i_vld & ~i_bad;
    assign w_serr = w_good & r_seq_vld[i_id] & (r_exp[i_id] != i_seq);
    assign o_data = r_data;

    // Next expected seq per id; only meaningful while its valid flag is set.
    always_ff @(posedge clk) begin
        if (w_good) begin
            r_exp[i_id] <= i_seq + 32'd1;
        end
    end

    // Expectation valid flags, dropped when a new measurement starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_vld <= '0;
        end else if (i_clear) begin
            r_seq_vld <= '0;
        end else if (w_good) begin
            r_seq_vld[i_id] <= 1'b1;
        end
    end

    // Commit stage: frame summary plus seq verdict; start kills in-flight frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_id   <= '0;
            r_s2_len  <= '0;
            r_s2_bad  <= 1'b0;
            r_s2_serr <= 1'b0;
        end else begin
            r_s2_vld  <= i_vld & ~i_clear;
            r_s2_id   <= i_id;
            r_s2_len  <= i_len;
            r_s2_bad  <= i_bad;
            r_s2_serr <= w_serr;
        end
    end

    // Counter bank, all wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORT; i++) begin
                r_frames[i] <= '0;
                r_bytes[i]  <= '0;
                r_serr[i]   <= '0;
                r_bad[i]    <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < NPORT; i++) begin
                r_frames[i] <= '0;
                r_bytes[i]  <= '0;
                r_serr[i]   <= '0;
                r_bad[i]    <= '0;
            end
        end else if (r_s2_vld) begin
            r_frames[r_s2_id] <= r_frames[r_s2_id] + 48'd1;
            r_bytes[r_s2_id]  <= r_bytes[r_s2_id] + {48'd0, r_s2_len};
            r_serr[r_s2_id]   <= r_serr[r_s2_id] + {31'd0, r_s2_serr};
            r_bad[r_s2_id]    <= r_bad[r_s2_id] + {31'd0, r_s2_bad};
        end
    end

    // Readout select.
    always_comb begin
        w_rd = '0;
        unique case (i_sel)
            SEL_FRAMES: w_rd = {16'd0, r_frames[i_port]};
            SEL_BYTES:  w_rd = r_bytes[i_port];
            SEL_SEQERR: w_rd = {32'd0, r_serr[i_port]};
            SEL_BAD:    w_rd = {32'd0, r_bad[i_port]};
        endcase
    end

    // Registered stats output, refreshed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_rd;
        end
    end
endmodule

// File: rtl/frame_checker.sv
// Test-frame checker: tracks AXIS frames, validates header/length/user,
// and feeds per-id statistics. Never backpressures.
module frame_checker
    import frame_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic                start,
    input  logic                stop,
    frame_checker_if.slave      axis,
    input  logic [ID_WIDTH-1:0] stats_port,
    input  logic [1:0]          stats_sel,
    output logic [63:0]         stats_data
);
    localparam int KW = DATA_WIDTH / 8;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_first;
    logic                 r_cnt;
    logic                 r_uerr;
    logic [ID_WIDTH-1:0]  r_id;
    logic [15:0]          r_etype;
    logic [31:0]          r_seq;
    logic [15:0]          r_len;
    logic [HDR_BYTES-1:0] r_hkeep;
    logic                 r_s1_vld;
    logic [ID_WIDTH-1:0]  r_s1_id;
    logic [31:0]          r_s1_seq;
    logic [15:0]          r_s1_len;
    logic                 r_s1_bad;

    logic [DATA_WIDTH-1:0] w_data;
    logic [KW-1:0]         w_keep;
    logic                  w_acc;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_open;
    logic [15:0]           w_beat_len;
    logic [16:0]           w_len_sum;
    logic [15:0]           w_len;
    logic                  w_uerr;
    logic                  w_cnt;
    logic [ID_WIDTH-1:0]   w_id;
    logic [15:0]           w_etype;
    logic [31:0]           w_seq;
    logic [HDR_BYTES-1:0]  w_hkeep;
    logic                  w_bad;

    assign axis.axis_s_ready = 1'b1;
    assign ready   = r_ready;
    assign w_data  = axis.axis_s_data;
    assign w_keep  = axis.axis_s_keep;
    assign w_acc   = axis.axis_s_valid;
    assign w_last  = axis.axis_s_last;
    assign w_clear = start & (r_state == ST_IDLE);
    assign w_open  = w_acc ? ~w_last : ~r_first;

    // Running frame totals merged with the current beat.
    assign w_beat_len = 16'($countones(w_keep));
    assign w_len_sum  = {1'b0, r_first ? 16'd0 : r_len} + {1'b0, w_beat_len};
    assign w_len      = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
    assign w_uerr     = (~r_first & r_uerr) | (|(axis.axis_s_user & w_keep));
    assign w_cnt      = r_first ? (r_state == ST_RUN) : r_cnt;
    assign w_id       = r_first ? axis.axis_s_id : r_id;
    assign w_hkeep    = r_first ? w_keep[HDR_BYTES-1:0] : r_hkeep;
    assign w_etype    = r_first ? {w_data[8*OFF_ETYPE +: 8],
                                   w_data[8*(OFF_ETYPE+1) +: 8]} : r_etype;
    assign w_seq      = r_first ? {w_data[8*OFF_SEQ +: 8],
                                   w_data[8*(OFF_SEQ+1) +: 8],
                                   w_data[8*(OFF_SEQ+2) +: 8],
                                   w_data[8*(OFF_SEQ+3) +: 8]} : r_seq;

    // A header cut short by keep cannot carry the test ethertype.
    assign w_bad = w_uerr | (w_len < MIN_FRAME_LEN) |
                   (w_etype != ETHERTYPE_TEST) | ~(&w_hkeep);

    // Control FSM with registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop && w_open) begin
                        r_state <= ST_FLUSH;
                    end else if (stop) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (w_acc && w_last) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Frame tracker: header capture on the first beat, totals on every beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_cnt   <= 1'b0;
            r_uerr  <= 1'b0;
            r_id    <= '0;
            r_etype <= '0;
            r_seq   <= '0;
            r_len   <= '0;
            r_hkeep <= '0;
        end else if (w_acc) begin
            r_first <= w_last;
            r_cnt   <= w_cnt;
            r_uerr  <= w_uerr;
            r_id    <= w_id;
            r_etype <= w_etype;
            r_seq   <= w_seq;
            r_len   <= w_len;
            r_hkeep <= w_hkeep;
        end
    end

    // First pipeline stage: completed, counted frame summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_id  <= '0;
            r_s1_seq <= '0;
            r_s1_len <= '0;
            r_s1_bad <= 1'b0;
        end else begin
            r_s1_vld <= w_acc & w_last & w_cnt;
            r_s1_id  <= w_id;
            r_s1_seq <= w_seq;
            r_s1_len <= w_len;
            r_s1_bad <= w_bad;
        end
    end

    frame_checker_stats #(
        .ID_WIDTH (ID_WIDTH)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_vld   (r_s1_vld),
        .i_id    (r_s1_id),
        .i_seq   (r_s1_seq),
        .i_len   (r_s1_len),
        .i_bad   (r_s1_bad),
        .i_port  (stats_port),
        .i_sel   (stats_sel),
        .o_data  (stats_data)
    );
endmodule

// File: tb/tb_frame_checker.sv
// Randomized scoreboard bench for frame_checker.
// Frames are modelled as byte lists; stats and ready reads are queued and checked by a monitor.
module tb_frame_checker;
    localparam int DW = 512;
    localparam int IW = 3;
    localparam int KW = DW / 8;
    localparam int NP = 1 << IW;

    typedef struct {
        string       nm;
        logic [63:0] val;
        bit          is_rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ready;
    logic [IW-1:0] stats_port = '0;
    logic [1:0]    stats_sel = '0;
    logic [63:0]   stats_data;

    frame_checker_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) axis_if ();

    frame_checker #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready      (ready),
        .start      (start),
        .stop       (stop),
        .axis       (axis_if.slave),
        .stats_port (stats_port),
        .stats_sel  (stats_sel),
        .stats_data (stats_data)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    bit           chk_req = 0;
    int           n_chk = 0;
    int           n_err = 0;
    byte unsigned fq[$];

    longint unsigned m_frames[NP];
    longint unsigned m_bytes[NP];
    int unsigned     m_serr[NP];
    int unsigned     m_bad[NP];
    int unsigned     m_exp[NP];
    bit              m_has[NP];
    bit              m_run = 0;

    // Monitor: compares whatever the stimulus asked to be observed this cycle.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                chk_req = 0;
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_empty: no expected value queued");
                end else begin
                    e = sb.pop_front();
                    act = e.is_rdy ? {63'd0, ready} : stats_data;
                    if (act !== e.val) begin
                        n_err++;
                        $display("FAIL %s: got %0h, expected %0h", e.nm, act, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < NP; i++) begin
            m_frames[i] = 0;
            m_bytes[i]  = 0;
            m_serr[i]   = 0;
            m_bad[i]    = 0;
            m_has[i]    = 0;
        end
    endfunction

    // Reference: judge the byte list in fq as one counted frame.
    function automatic void model_frame(int id, bit uerr);
        int          len;
        logic [15:0] et;
        logic [31:0] sq;
        bit          bad;
        len = fq.size();
        et  = (len >= 14) ? {fq[12], fq[13]} : 16'h0000;
        sq  = (len >= 18) ? {fq[14], fq[15], fq[16], fq[17]} : 32'd0;
        bad = uerr || (len < 60) || (et != 16'h88B5);
        m_frames[id]++;
        m_bytes[id] += len;
        if (bad) begin
            m_bad[id]++;
        end else begin
            if (m_has[id] && (m_exp[id] != sq)) m_serr[id]++;
            m_exp[id] = sq + 1;
            m_has[id] = 1;
        end
    endfunction

    function automatic void mk_frame(int len, logic [15:0] et, logic [31:0] sq);
        fq.delete();
        for (int i = 0; i < len; i++) fq.push_back(byte'($urandom));
        if (len > 12) fq[12] = et[15:8];
        if (len > 13) fq[13] = et[7:0];
        for (int k = 0; k < 4; k++)
            if (14 + k < len) fq[14+k] = sq[31-8*k -: 8];
    endfunction

    task automatic push_chk(input string nm, input logic [63:0] v, input bit r);
        exp_t e;
        e.nm = nm;
        e.val = v;
        e.is_rdy = r;
        sb.push_back(e);
        chk_req = 1;
    endtask

    task automatic check_item(input string nm, input logic [63:0] v, input bit r);
        push_chk(nm, v, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_stat(input int p, input int s);
        logic [63:0] v;
        stats_port = p[IW-1:0];
        stats_sel  = s[1:0];
        @(posedge clk);
        #1;
        case (s)
            0: v = m_frames[p];
            1: v = m_bytes[p];
            2: v = {32'd0, m_serr[p]};
            default: v = {32'd0, m_bad[p]};
        endcase
        check_item($sformatf("port%0d_sel%0d", p, s), v, 0);
    endtask

    task automatic check_port(input int p);
        for (int s = 0; s < 4; s++) read_stat(p, s);
    endtask

    task automatic check_all();
        idle(4);
        for (int p = 0; p < NP; p++) check_port(p);
    endtask

    task automatic do_start();
        start = 1;
        idle(1);
        start = 0;
        model_clear();
        m_run = 1;
    endtask

    task automatic do_stop();
        stop = 1;
        idle(1);
        stop = 0;
        m_run = 0;
    endtask

    task automatic fill_beat(input int b, output logic [DW-1:0] d,
                             output logic [KW-1:0] k, output logic [KW-1:0] u);
        int idx;
        for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
        for (int j = 0; j < KW; j++) u[j] = 1'($urandom_range(0, 1));
        k = '0;
        for (int j = 0; j < KW; j++) begin
            idx = b * KW + j;
            if (idx < fq.size()) begin
                d[8*j +: 8] = fq[idx];
                k[j] = 1'b1;
                u[j] = 1'b0;
            end
        end
    endtask

    task automatic drive_beat(input int id, input logic [DW-1:0] d,
                              input logic [KW-1:0] k, input logic [KW-1:0] u,
                              input logic l, input bit stp, input bit rchk);
        axis_if.axis_s_valid = 1'b1;
        axis_if.axis_s_data  = d;
        axis_if.axis_s_keep  = k;
        axis_if.axis_s_user  = u;
        axis_if.axis_s_last  = l;
        axis_if.axis_s_id    = id[IW-1:0];
        stop = stp;
        if (rchk) push_chk("flush_ready", 64'd0, 1);
        @(posedge clk);
        #1;
        axis_if.axis_s_valid = 1'b0;
        axis_if.axis_s_data  = '0;
        axis_if.axis_s_last  = 1'b0;
        stop = 1'b0;
    endtask

    // Sends fq as one frame; ue_beat >= 0 plants a user error at lane ue_bit.
    task automatic send_frame(input int id, input int ue_beat, input int ue_bit,
                              input int stop_beat);
        int            nb;
        bit            cnt;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [KW-1:0] u;
        nb  = (fq.size() + KW - 1) / KW;
        cnt = m_run;
        for (int b = 0; b < nb; b++) begin
            fill_beat(b, d, k, u);
            if (b == ue_beat) u[ue_bit] = 1'b1;
            if (stop_beat < 0) idle($urandom_range(0, 1));
            drive_beat(id, d, k, u, b == nb - 1, b == stop_beat,
                       (stop_beat >= 0) && (b > stop_beat));
            if (b == stop_beat) m_run = 0;
        end
        if (cnt) model_frame(id, ue_beat >= 0);
    endtask

    initial begin
        int            id;
        int            len;
        int            nb;
        int            ueb;
        int            uebit;
        int            nbytes;
        logic [15:0]   et;
        logic [31:0]   sq;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [KW-1:0] u;
        byte unsigned  tail[$];

        axis_if.axis_s_valid = 1'b0;
        axis_if.axis_s_data  = '0;
        axis_if.axis_s_keep  = '0;
        axis_if.axis_s_user  = '0;
        axis_if.axis_s_last  = 1'b0;
        axis_if.axis_s_id    = '0;
        model_clear();
        idle(3);
        rst_n = 1;
        idle(2);

        check_item("reset_ready", 64'd1, 1);
        n_chk++;
        if (axis_if.axis_s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL axis_ready: got %b, expected 1", axis_if.axis_s_ready);
        end
        check_all();

        do_start();
        check_item("run_ready", 64'd0, 1);

        for (int i = 0; i < 10; i++) begin
            mk_frame(64, 16'h88B5, i);
            send_frame(2, -1, 0, -1);
        end
        mk_frame(64, 16'h88B5, 0);          send_frame(1, -1, 0, -1);
        mk_frame(64, 16'h88B5, 1);          send_frame(1, -1, 0, -1);
        mk_frame(64, 16'h88B5, 3);          send_frame(1, -1, 0, -1);
        mk_frame(64, 16'h88B5, 4);          send_frame(1, -1, 0, -1);
        mk_frame(64, 16'h88B5, 5);          send_frame(3, -1, 0, -1);
        mk_frame(150, 16'h88B5, 100);       send_frame(3, 1, 5, -1);
        mk_frame(64, 16'h88B5, 6);          send_frame(3, -1, 0, -1);
        mk_frame(64, 16'h88B5, 32'hFFFFFFFF); send_frame(0, -1, 0, -1);
        mk_frame(64, 16'h88B5, 0);          send_frame(0, -1, 0, -1);
        mk_frame(40, 16'h88B5, 0);          send_frame(4, -1, 0, -1);
        mk_frame(64, 16'h0800, 1);          send_frame(4, -1, 0, -1);
        check_all();

        for (int i = 0; i < 60; i++) begin
            id = $urandom_range(0, NP - 1);
            len = $urandom_range(40, 300);
            et = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h88B5;
            sq = (m_has[id] && $urandom_range(0, 3) != 0) ? m_exp[id] : $urandom;
            mk_frame(len, et, sq);
            nb = (len + KW - 1) / KW;
            ueb = -1;
            uebit = 0;
            if ($urandom_range(0, 7) == 0) begin
                ueb = $urandom_range(0, nb - 1);
                nbytes = (len - ueb * KW > KW) ? KW : len - ueb * KW;
                uebit = $urandom_range(0, nbytes - 1);
            end
            send_frame(id, ueb, uebit, -1);
        end
        check_all();

        do_stop();
        check_item("idle_ready", 64'd1, 1);
        mk_frame(64, 16'h88B5, 0);
        send_frame(5, -1, 0, -1);
        check_all();

        do_start();
        check_port(2);
        mk_frame(150, 16'h88B5, 0);
        send_frame(7, -1, 0, 1);
        check_item("after_last_ready", 64'd1, 1);
        check_all();

        do_start();
        mk_frame(64, 16'h88B5, 9);
        send_frame(5, -1, 0, -1);
        idle(4);
        read_stat(5, 0);
        mk_frame(100, 16'h88B5, 7);
        fill_beat(0, d, k, u);
        drive_beat(6, d, k, u, 1'b0, 1'b0, 1'b0);
        rst_n = 0;
        check_item("rst_stats", 64'd0, 0);
        check_item("rst_ready", 64'd1, 1);
        rst_n = 1;
        model_clear();
        m_run = 0;
        idle(1);
        do_start();
        tail.delete();
        for (int i = KW; i < fq.size(); i++) tail.push_back(fq[i]);
        fq = tail;
        send_frame(6, -1, 0, -1);
        check_all();

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
